// File: rtl/acquire_trig_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : acquire_pkg                                                |
// | Brief   : Shared state, mode and edge encodings for acquire_trig.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package acquire_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } acq_state_e;

  localparam logic MODE_SCOPE = 1'b0;
  localparam logic MODE_LA    = 1'b1;
  localparam logic EDGE_FALL  = 1'b0;
  localparam logic EDGE_RISE  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/acquire_trig_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : acquire_trig_if                                            |
// | Brief   : Control, ADC and RAM-write signals of the capture engine.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface acquire_trig_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              grant;
  logic              abort;
  logic              mode;
  logic              trig_en;
  logic              trig_edge;
  logic [DATA_W-1:0] threshold;
  logic [DATA_W-1:0] adc_data;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  modport master (
    output grant, abort, mode, trig_en, trig_edge, threshold, adc_data,
    input  done, busy, wr_addr, wr_data, wr_en
  );

  modport slave (
    input  grant, abort, mode, trig_en, trig_edge, threshold, adc_data,
    output done, busy, wr_addr, wr_data, wr_en
  );
endinterface
`default_nettype wire

// File: rtl/acquire_trig_trigger.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : acq_trigger                                                |
// | Brief   : Latched threshold compare and edge-crossing trigger.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module acq_trigger
  import acquire_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              load,
  input  wire logic              clr,
  input  wire logic              arm,
  input  wire logic              trig_en,
  input  wire logic              trig_edge,
  input  wire logic [DATA_W-1:0] threshold_in,
  input  wire logic [DATA_W-1:0] adc_data,
  output logic                   above,
  output logic                   trig
);

  logic [DATA_W-1:0] r_thr;
  logic              r_prev;
  logic              r_prev_vld;
  logic              w_edge_hit;

  assign above = (adc_data >= r_thr);

  assign w_edge_hit = (trig_edge == EDGE_RISE) ? (!r_prev && above)
                                               : (r_prev && !above);

  // The first ARM cycle only seeds r_prev, so an edge cannot fire on it.
  assign trig = arm && (!trig_en || (r_prev_vld && w_edge_hit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr      <= '0;
      r_prev     <= 1'b0;
      r_prev_vld <= 1'b0;
    end else if (clr) begin
      r_prev     <= 1'b0;
      r_prev_vld <= 1'b0;
    end else if (load) begin
      r_thr      <= threshold_in;
      r_prev     <= 1'b0;
      r_prev_vld <= 1'b0;
    end else if (arm) begin
      r_prev     <= above;
      r_prev_vld <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/acquire_trig.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : acquire_trig                                               |
// | Brief   : Triggered capture engine filling the sample RAM once.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module acquire_trig
  import acquire_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  acquire_trig_if.slave bus
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] c_st_idle    = IDLE;
  localparam logic [1:0] c_st_arm     = ARM;
  localparam logic [1:0] c_st_capture = CAPTURE;
  localparam logic [1:0] c_st_done    = DONE;

  logic [1:0]        r_state;
  logic              r_mode;
  logic              r_trig_en;
  logic              r_trig_edge;
  logic [ADDR_W-1:0] r_widx;
  logic              r_full;
  logic [BIT_W-1:0]  r_bitcnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_done;

  logic              w_accept;
  logic              w_arm;
  logic              w_above;
  logic              w_trig;
  logic              w_capture;
  logic              w_word_done;
  logic [DATA_W-1:0] w_la_word;
  logic [DATA_W-1:0] w_word;

  assign w_accept = (r_state == c_st_idle) && bus.grant && !bus.abort;
  assign w_arm    = (r_state == c_st_arm) && !bus.abort;

  acq_trigger #(
    .DATA_W (DATA_W)
  ) u_trigger (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (w_accept),
    .clr          (bus.abort),
    .arm          (w_arm),
    .trig_en      (r_trig_en),
    .trig_edge    (r_trig_edge),
    .threshold_in (bus.threshold),
    .adc_data     (bus.adc_data),
    .above        (w_above),
    .trig         (w_trig)
  );

  // The trigger sample itself is captured, then one sample per CAPTURE cycle.
  assign w_capture = !bus.abort &&
                     ((w_arm && w_trig) || ((r_state == c_st_capture) && !r_full));

  always_comb begin
    w_la_word           = r_shift;
    w_la_word[r_bitcnt] = w_above;
  end

  assign w_word_done = w_capture &&
                       ((r_mode == MODE_SCOPE) || (r_bitcnt == BIT_W'(DATA_W - 1)));
  assign w_word      = (r_mode == MODE_SCOPE) ? bus.adc_data : w_la_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_mode      <= MODE_SCOPE;
      r_trig_en   <= 1'b0;
      r_trig_edge <= EDGE_FALL;
      r_widx      <= '0;
      r_full      <= 1'b0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (bus.abort) begin
        r_state   <= c_st_idle;
        r_widx    <= '0;
        r_full    <= 1'b0;
        r_bitcnt  <= '0;
        r_shift   <= '0;
        r_wr_addr <= '0;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (bus.grant) begin
              r_state     <= c_st_arm;
              r_mode      <= bus.mode;
              r_trig_en   <= bus.trig_en;
              r_trig_edge <= bus.trig_edge;
            end
          end
          c_st_arm: begin
            if (w_trig) r_state <= c_st_capture;
          end
          c_st_capture: begin
            // r_full means the final word is on the write port this cycle.
            if (r_full) begin
              r_state   <= c_st_done;
              r_done    <= 1'b1;
              r_widx    <= '0;
              r_full    <= 1'b0;
              r_wr_addr <= '0;
            end
          end
          c_st_done: r_state <= c_st_idle;
          default:   r_state <= c_st_idle;
        endcase

        if (w_capture) begin
          if (r_mode == MODE_LA) begin
            if (w_word_done) begin
              r_bitcnt <= '0;
              r_shift  <= '0;
            end else begin
              r_bitcnt <= r_bitcnt + BIT_W'(1);
              r_shift  <= w_la_word;
            end
          end
          if (w_word_done) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_widx;
            r_wr_data <= w_word;
            r_widx    <= r_widx + ADDR_W'(1);
            if (&r_widx) r_full <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.busy    = (r_state == c_st_arm) || (r_state == c_st_capture);
  assign bus.done    = r_done;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_acquire_trig.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_acquire_trig                                            |
// | Brief   : Scoreboard bench for acquire_trig (DATA_W=8, ADDR_W=4).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_acquire_trig;

  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int NW     = 1 << AW;
  localparam int STIM_N = 512;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_done_cyc = -1;
  int   last_g = 0;

  exp_t wq[$];
  int   dq[$];
  logic [DW-1:0] stim [0:STIM_N-1];

  acquire_trig_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  acquire_trig #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Trigger index within stim[] (index 0 = grant cycle, 1 = first ARM cycle).
  function automatic int find_trig(input bit te, input bit ed, input logic [DW-1:0] th);
    if (!te) return 1;
    for (int i = 2; i < STIM_N; i++) begin
      bit p, a;
      p = (stim[i-1] >= th);
      a = (stim[i] >= th);
      if (ed ? (!p && a) : (p && !a)) return i;
    end
    return -1;
  endfunction

  // Monitor: pops expectations whenever the DUT writes or pulses done.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.wr_en) begin
      if (wq.size() == 0) chk("unexpected_write", bus.wr_en, 0);
      else begin
        exp_t e;
        e = wq.pop_front();
        chk("wr_addr", bus.wr_addr, e.addr);
        chk("wr_data", bus.wr_data, e.data);
        chk("wr_cycle", cyc_cnt, e.cyc);
      end
    end
    if (rst_n && bus.done) begin
      last_done_cyc = cyc_cnt;
      chk("busy_at_done", bus.busy, 0);
      if (dq.size() == 0) chk("unexpected_done", bus.done, 0);
      else chk("done_cycle", cyc_cnt, dq.pop_front());
    end
  end

  task automatic run(input bit m, input bit te, input bit ed, input logic [DW-1:0] th,
                     input int abort_word, input bit hold, input int rst_off, input bit scramble);
    int t, g, off, last_off, done_off, abort_off, end_off;
    bit did_rst;
    t = find_trig(te, ed, th);
    if (t < 0 || t + NW * DW + 4 >= STIM_N) begin
      errors++; checks++;
      $display("FAIL model_trigger: got %0d expected index below %0d", t, STIM_N - NW * DW - 4);
      return;
    end
    @(negedge clk);
    g = cyc_cnt;
    last_g = g;
    bus.grant = 1'b1; bus.abort = 1'b0;
    bus.mode = m; bus.trig_en = te; bus.trig_edge = ed; bus.threshold = th;
    bus.adc_data = stim[0];

    abort_off = -1; last_off = 0;
    for (int k = 0; k < NW; k++) begin
      exp_t e;
      int d;
      if (!m) begin
        d = stim[t + k];
        off = t + 1 + k;
      end else begin
        d = 0;
        for (int j = 0; j < DW; j++) if (stim[t + k * DW + j] >= th) d |= (1 << j);
        off = t + (k + 1) * DW;
      end
      if (abort_word < 0 || k <= abort_word) begin
        e.addr = k; e.data = d; e.cyc = g + off;
        wq.push_back(e);
      end
      if (k == abort_word) abort_off = off;
      last_off = off;
    end
    done_off = last_off + 1;
    if (abort_word < 0) dq.push_back(g + done_off);

    if (rst_off > 0)        end_off = rst_off;
    else if (abort_word >= 0) end_off = abort_off + 2;
    else if (hold)          end_off = done_off;
    else                    end_off = done_off + 1;

    did_rst = 1'b0;
    for (int i = 1; i <= end_off; i++) begin
      @(negedge clk);
      if (i == rst_off) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_done", bus.done, 0);
        wq.delete(); dq.delete();
        bus.grant = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        did_rst = 1'b1;
        break;
      end
      bus.grant    = hold;
      bus.adc_data = (i < STIM_N) ? stim[i] : DW'($urandom);
      bus.abort    = (abort_word >= 0 && i == abort_off);
      if (scramble) begin
        bus.mode = 1'($urandom); bus.trig_en = 1'($urandom);
        bus.trig_edge = 1'($urandom); bus.threshold = DW'($urandom);
      end
      if (i == 1) chk("busy_after_grant", bus.busy, 1);
      if (te && t > 3 && i == t - 1) chk("busy_while_armed", bus.busy, 1);
      if (abort_word >= 0 && i == abort_off + 1) begin
        chk("abort_wr_en", bus.wr_en, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_wr_addr", bus.wr_addr, 0);
      end
      if (abort_word < 0 && !hold && i == done_off + 1) chk("idle_wr_addr", bus.wr_addr, 0);
    end
    bus.abort = 1'b0;
    if (!did_rst) begin
      chk("pending_writes", wq.size(), 0);
      chk("pending_done", dq.size(), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m, te, ed;
    logic [DW-1:0] th;
    int t;
    rst_n = 1'b0;
    bus.grant = 0; bus.abort = 0; bus.mode = 0; bus.trig_en = 0;
    bus.trig_edge = 0; bus.threshold = 0; bus.adc_data = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_wr_en", bus.wr_en, 0);
    chk("reset_wr_addr", bus.wr_addr, 0);
    chk("reset_wr_data", bus.wr_data, 0);
    chk("reset_done", bus.done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Scope, immediate start on a ramp.
    for (int i = 0; i < STIM_N; i++) stim[i] = DW'(i);
    run(1'b0, 1'b0, 1'b0, DW'($urandom), -1, 1'b0, 0, 1'b1);
    chk("done_at_g_plus_18", last_done_cyc, last_g + 18);

    // Scope, rising crossing of 0x80.
    for (int i = 0; i < STIM_N; i++) stim[i] = (i < 6) ? 8'h10 : DW'(8'h90 + (i - 6));
    run(1'b0, 1'b1, 1'b1, 8'h80, -1, 1'b0, 0, 1'b1);

    // Falling edge: below at arm, rises, then the real high-to-low crossing.
    for (int i = 0; i < STIM_N; i++)
      stim[i] = (i <= 10) ? 8'h20 : (i <= 15) ? 8'hC0 : DW'(8'h30 + (i % 64));
    run(1'b0, 1'b1, 1'b0, 8'h80, -1, 1'b0, 0, 1'b1);

    // Logic analyser, alternating above/below starting above.
    for (int i = 0; i < STIM_N; i++)
      stim[i] = (i % 2 == 1) ? DW'(8'h80 + $urandom_range(0, 127)) : DW'($urandom_range(0, 127));
    run(1'b1, 1'b0, 1'b0, 8'h80, -1, 1'b0, 0, 1'b1);

    // Abort at the write of address 5, then a fresh capture from address 0.
    for (int i = 0; i < STIM_N; i++) stim[i] = DW'($urandom);
    run(1'b0, 1'b0, 1'b0, 8'h40, 5, 1'b0, 0, 1'b0);
    run(1'b0, 1'b0, 1'b0, 8'h40, -1, 1'b0, 0, 1'b0);

    // Reset mid-capture, then recovery.
    run(1'b0, 1'b0, 1'b0, 8'h40, -1, 1'b0, 10, 1'b0);
    run(1'b1, 1'b0, 1'b0, 8'h90, -1, 1'b0, 0, 1'b0);

    // Grant held through the capture, re-accepted right after done.
    run(1'b0, 1'b0, 1'b0, 8'h40, -1, 1'b1, 0, 1'b0);
    run(1'b1, 1'b0, 1'b0, 8'h40, -1, 1'b0, 0, 1'b0);

    // Randomised captures.
    repeat (6) begin
      m  = 1'($urandom);
      te = 1'($urandom);
      ed = 1'($urandom);
      th = DW'($urandom_range(32, 224));
      do begin
        for (int i = 0; i < STIM_N; i++) stim[i] = DW'($urandom);
        t = find_trig(te, ed, th);
      end while (t < 0 || t > 150);
      run(m, te, ed, th, -1, 1'b0, 0, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acquire_trig.md
# acquire_trig

Parametrised capture engine between the ADC front end and the sample RAM. After the RAM arbiter grants access, it arms and waits for a threshold-crossing trigger (or starts immediately). It then fills the whole RAM with either raw samples (oscilloscope mode) or threshold-sliced bits packed into words (logic-analyser mode). A one-cycle `done` pulse marks the end of a capture.

## Interface
- `DATA_W`, default 8: ADC sample width, RAM word width, and bits packed per word in logic-analyser mode.
- `ADDR_W`, default 10: RAM address width; one capture is exactly 2^ADDR_W words.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `grant` in 1: RAM granted; starts a capture when the block is in IDLE.
- `abort` in 1: cancels a capture from any state.
- `mode` in 1: 0 = scope (raw samples), 1 = logic analyser (packed bits).
- `trig_en` in 1: 0 = start immediately, 1 = wait for an edge.
- `trig_edge` in 1: 0 = falling crossing, 1 = rising crossing.
- `threshold` in DATA_W: unsigned slice level.
- `adc_data` in DATA_W: unsigned sample, valid every cycle.
- `done` out 1: one-cycle pulse after the last write.
- `busy` out 1: high in ARM and CAPTURE.
- `wr_addr` out ADDR_W: RAM write address.
- `wr_data` out DATA_W: RAM write data.
- `wr_en` out 1: RAM write strobe.

## Operation
- Reset values: all outputs 0; state IDLE; address counter 0; bit counter 0; shift register 0; prev-level flag invalid.
- States and transitions:
  - IDLE: leaves to ARM when `grant` is 1.
  - ARM: leaves to CAPTURE on the trigger.
  - CAPTURE: leaves to DONE after the last word has been issued.
  - DONE: returns to IDLE after one cycle.
- On the cycle `grant` is accepted in IDLE, `mode`, `trig_en`, `trig_edge` and `threshold` are latched. Later changes have no effect until the next capture.
- `grant` is ignored outside IDLE.
- Level: `above` = (`adc_data` >= latched `threshold`), unsigned compare.
- Trigger when `trig_en` = 0: the first ARM-cycle sample is the trigger sample.
- Trigger when `trig_en` = 1:
  - The first ARM cycle only loads the previous-level flag; no trigger can fire on it.
  - From the second ARM cycle on, a rising trigger is prev=0 and `above`=1; a falling trigger is prev=1 and `above`=0.
  - ARM waits indefinitely.
- The trigger sample is the first captured sample. Every following cycle in CAPTURE captures one more sample, with no gaps.
- Scope mode: each captured sample becomes one word, written at consecutive addresses from 0.
- Logic-analyser mode:
  - Each captured sample contributes one bit, `above`. The first captured sample goes into bit 0, and later samples fill upward (LSB-first).
  - After DATA_W bits the full word is written and the bit counter wraps to 0.
- Capture ends after the word at address 2^ADDR_W−1 is written. There is no wrap into a second pass.
- `abort`:
  - Takes priority over every other event, including `grant`, the trigger, and the last write in the same cycle.
  - Returns the block to IDLE on the next edge. `wr_en` is 0 from that cycle on, and `done` is never pulsed.
  - Clears the address counter, bit counter and prev-level flag.
- Reset asserted mid-capture behaves like abort, but takes effect immediately (asynchronously).

## Timing
- `wr_en`, `wr_addr`, `wr_data` and `done` are all registered.
- Write latency: a word completed in cycle N is presented with `wr_en`=1 in cycle N+1.
- Let T be the trigger cycle.
  - Scope mode: word k is written at cycle T+1+k; the last write is at T+2^ADDR_W.
  - Logic-analyser mode: word k is written at cycle T+(k+1)·DATA_W.
- `done` is high exactly one cycle, immediately after the last write. The next cycle is IDLE, and `grant` may be accepted there.
- Grant sampled in cycle G:
  - `busy` rises in G+1.
  - With `trig_en`=0, T = G+1.
  - `busy` falls in the DONE cycle.
- `wr_addr` holds its last value while `wr_en` is 0. It returns to 0 at DONE and on abort.

## Structure
- `acquire_pkg` holds:
  - the state enum (IDLE, ARM, CAPTURE, DONE);
  - the mode constants MODE_SCOPE = 0 and MODE_LA = 1;
  - the edge constants EDGE_FALL = 0 and EDGE_RISE = 1.
- Sub-module `acq_trigger` holds:
  - the latched threshold compare, the prev-level flag and its valid bit, and the edge detect;
  - its outputs are `above` and `trig`.
- The top level holds the FSM, the address counter, and the bit counter plus shift register.

## Test plan
All scenarios use DATA_W=8, ADDR_W=4.
- Scope, immediate start: `trig_en`=0 with ramp `adc_data`=0,1,2,… and grant in cycle G → 16 writes, addr 0..15, data 1..16, `done` at G+18.
- Scope, rising trigger: threshold=0x80, input 0x10 ×5 then 0x90,0x91,… → first write has addr 0, data 0x90, exactly one cycle after the crossing.
- Falling-edge false start: input already below threshold at arm with `trig_edge`=0 → no trigger until a high→low crossing occurs; `busy` stays 1 meanwhile.
- Logic analyser: `trig_en`=0 with input alternating above/below threshold (first sample above) → 16 writes of 0x55, spaced 8 cycles apart.
- Abort: assert `abort` at the write of addr 5 → `wr_en`=0 next cycle, no `done`, state IDLE; a new grant restarts at addr 0.
- Reset and grant corner cases: `rst_n` low mid-capture → all outputs 0 at once; `grant` held high during CAPTURE → no restart; grant in the cycle after `done` → new capture accepted.
